// File: rtl/serial_window_pkg.sv
// Shared definitions for serial_window_matcher.
//   state_t            : FSM encoding (IDLE / FILL / RUN)
//   DEF_WIDTH, DEF_CNT_W : default window width and match counter width
package serial_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no pattern loaded yet, serial bits are ignored
    ST_FILL = 2'd1,  // collecting the first WIDTH bits of a window
    ST_RUN  = 2'd2   // window full, every accepted bit is compared
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/eq_nbit.sv
// Bitwise equality comparator: eq is high when every bit of a equals the
// corresponding bit of b (per-bit XNOR followed by an AND-reduce).
// Ports:
//   a, b : WIDTH-bit operands
//   eq   : 1 when a == b
module eq_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = &(a ~^ b);

endmodule

// File: rtl/serial_window_matcher.sv
// Serial pattern detector. Shifts a 1-bit stream into a WIDTH-bit window
// (newest bit in bit 0) and compares the window with a loaded pattern on
// every accepted bit, producing a registered one-cycle match pulse and a
// saturating match counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load_pat, pat_in    : load a new pattern (restarts the window fill)
//   clr_count           : clear match_count (wins over a same-cycle match)
//   bit_valid, bit_in   : serial input, oldest bit first
//   window, window_full : current window and "WIDTH bits collected" flag
//   match, match_count  : match pulse and saturating count
//   pat_loaded          : a pattern has been loaded since reset
// Build option: define SERIAL_WINDOW_NONOVERLAP_EN to restart the window
// fill after every match (non-overlapping detection).
module serial_window_matcher
  import serial_window_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_pat,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             clr_count,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] window,
  output logic             window_full,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             pat_loaded
);

  localparam int            FW        = $clog2(WIDTH);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] window_shift, window_nxt;
  logic [FW-1:0]    fill_cnt, fill_nxt;
  logic             completes;
  logic             eq;
  logic             match_nxt;

  assign window_shift = {window[WIDTH-2:0], bit_in};

  // Compare the window as it will look after this bit, so the match pulse
  // lands exactly one cycle after the completing bit.
  eq_nbit #(.WIDTH(WIDTH)) u_eq (
    .a  (window_shift),
    .b  (pattern),
    .eq (eq)
  );

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    window_nxt = window;
    fill_nxt   = fill_cnt;
    completes  = 1'b0;
    match_nxt  = 1'b0;

    if (load_pat) begin
      // A load restarts the fill and drops any bit presented alongside it.
      state_nxt  = ST_FILL;
      window_nxt = '0;
      fill_nxt   = '0;
    end else if (bit_valid && (state != ST_IDLE)) begin
      window_nxt = window_shift;
      case (state)
        ST_FILL: begin
          if (fill_cnt == FILL_LAST) begin
            state_nxt = ST_RUN;
            completes = 1'b1;
          end else begin
            fill_nxt = fill_cnt + FW'(1);
          end
        end
        ST_RUN:  completes = 1'b1;
        default: ;
      endcase
      match_nxt = completes && eq;
`ifdef SERIAL_WINDOW_NONOVERLAP_EN
      if (match_nxt) begin
        state_nxt  = ST_FILL;
        window_nxt = '0;
        fill_nxt   = '0;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pattern     <= '0;
      window      <= '0;
      fill_cnt    <= '0;
      match       <= 1'b0;
      match_count <= '0;
      pat_loaded  <= 1'b0;
    end else begin
      state    <= state_nxt;
      window   <= window_nxt;
      fill_cnt <= fill_nxt;
      match    <= match_nxt;
      if (load_pat) begin
        pattern    <= pat_in;
        pat_loaded <= 1'b1;
      end
      if (clr_count) begin
        match_count <= '0;
      end else if (match_nxt && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  assign window_full = (state == ST_RUN);

endmodule

// File: tb/tb_serial_window_matcher.sv
// Self-checking bench for serial_window_matcher (WIDTH=4, CNT_W=2 so the
// counter saturates quickly). A reference model keeps the accepted bits
// since the last fill restart in a queue and decides matches from the last
// WIDTH of them; every cycle all outputs are compared against it, and the
// directed scenarios add fixed expected values.
module tb_serial_window_matcher;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_pat = 1'b0;
  logic [W-1:0]  pat_in = '0;
  logic          clr_count = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_in = 1'b0;
  logic [W-1:0]  window;
  logic          window_full;
  logic          match;
  logic [CW-1:0] match_count;
  logic          pat_loaded;

  serial_window_matcher #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_pat    (load_pat),
    .pat_in      (pat_in),
    .clr_count   (clr_count),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .window      (window),
    .window_full (window_full),
    .match       (match),
    .match_count (match_count),
    .pat_loaded  (pat_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit         q[$];
  bit [W-1:0] m_pat;
  bit         m_loaded;
  bit         m_match;
  int         m_count;

  function automatic bit [W-1:0] m_window();
    bit [W-1:0] w = '0;
    foreach (q[i]) w = {w[W-2:0], q[i]};
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      m_pat    = '0;
      m_loaded = 1'b0;
      m_match  = 1'b0;
      m_count  = 0;
    end else begin
      m_match = 1'b0;
      if (load_pat) begin
        m_pat    = pat_in;
        m_loaded = 1'b1;
        q.delete();
      end else if (bit_valid && m_loaded) begin
        q.push_back(bit_in);
        if (q.size() > W) void'(q.pop_front());
        if (q.size() == W && m_window() == m_pat) m_match = 1'b1;
`ifdef SERIAL_WINDOW_NONOVERLAP_EN
        if (m_match) q.delete();
`endif
      end
      if (clr_count) m_count = 0;
      else if (m_match && m_count < CMAX) m_count++;
    end
  endtask

  task automatic compare_all();
    check("window",      32'(window),      32'(m_window()));
    check("window_full", 32'(window_full), 32'(q.size() == W));
    check("match",       32'(match),       32'(m_match));
    check("match_count", 32'(match_count), 32'(m_count));
    check("pat_loaded",  32'(pat_loaded),  32'(m_loaded));
  endtask

  task automatic cycle(input bit r, input bit l, input logic [W-1:0] p,
                       input bit c, input bit v, input bit b);
    rst = r; load_pat = l; pat_in = p; clr_count = c; bit_valid = v; bit_in = b;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();                   cycle(1, 0, '0, 0, 0, 0); endtask
  task automatic do_load(input logic [W-1:0] p); cycle(0, 1, p, 0, 0, 0); endtask
  task automatic feed(input bit b);            cycle(0, 0, '0, 0, 1, b); endtask
  task automatic idle();                       cycle(0, 0, '0, 0, 0, 0); endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_window", 32'(window), 0);
    check("rst_count",  32'(match_count), 0);

    // Bits with no pattern loaded are ignored
    feed(1); feed(1); feed(0); feed(1); feed(1);
    check("idle_window", 32'(window), 0);
    check("idle_match",  32'(match), 0);

    // Pattern load and first match
    do_load(4'b1011);
    feed(1); feed(0); feed(1);
    check("first_nomatch_early", 32'(match), 0);
    feed(1);
    check("first_match",  32'(match), 1);
    check("first_count",  32'(match_count), 1);
    check("first_window", 32'(window), 32'(4'b1011));
    check("first_full",   32'(window_full), 1);
    idle();
    check("first_pulse_end", 32'(match), 0);

    // Overlapping matches
    do_reset();
    do_load(4'b1010);
    feed(1); feed(0); feed(1); feed(0);
    check("ovl_match4", 32'(match), 1);
    feed(1); feed(0);
`ifdef SERIAL_WINDOW_NONOVERLAP_EN
    check("ovl_count", 32'(match_count), 1);
`else
    check("ovl_count", 32'(match_count), 2);
`endif

    // Gaps: idle cycles hold the window and never match
    do_reset();
    do_load(4'b0000);
    feed(0); feed(0);
    idle(); check("gap_idle_match", 32'(match), 0);
    idle(); idle();
    feed(0);
    check("gap_nomatch3", 32'(match), 0);
    feed(0);
    check("gap_match", 32'(match), 1);
    check("gap_count", 32'(match_count), 1);

    // Load wins over a same-cycle valid bit
    cycle(0, 1, 4'b0110, 0, 1, 1);
    check("loadprio_window", 32'(window), 0);
    check("loadprio_full",   32'(window_full), 0);

    // Reload mid-stream: count retained, fill restarts
    do_reset();
    do_load(4'b1111);
    feed(1); feed(1); feed(1);
    do_load(4'b0001);
    feed(1);
    check("reload_match",  32'(match), 0);
    check("reload_window", 32'(window), 32'(4'b0001));
    check("reload_full",   32'(window_full), 0);
    check("reload_count",  32'(match_count), 0);

    // Saturation and clear priority
    do_reset();
    do_load(4'b0000);
    for (int i = 0; i < 7; i++) feed(0);
`ifdef SERIAL_WINDOW_NONOVERLAP_EN
    check("sat_count", 32'(match_count), 1);
`else
    check("sat_count", 32'(match_count), CMAX);
`endif
    cycle(0, 0, '0, 1, 1, 0);
    check("clr_match", 32'(match), 1);
    check("clr_count", 32'(match_count), 0);

    // Reset mid-stream clears everything
    feed(0); feed(0);
    do_reset();
    check("midrst_loaded", 32'(pat_loaded), 0);
    check("midrst_window", 32'(window), 0);
    check("midrst_match",  32'(match), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 24) == 0),
            W'($urandom),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
